// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: shared state encoding and default parameters for the pattern detector
package pattern_detector_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int         PAT_W_DEF   = 4;
    localparam logic [3:0] DEF_PAT_DEF = 4'b1011;
    localparam int         CNT_W_DEF   = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear has priority)
//   clk   - clock
//   reset - asynchronous active-low reset
//   inc   - count up by one (holds at all-ones)
//   clr   - synchronous clear to zero
//   count - registered count value
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: serial MSB-first pattern matcher with loadable pattern and saturating match count
//   clk        - clock
//   reset      - asynchronous active-low reset
//   ip         - serial data bit, sampled when ip_valid=1
//   ip_valid   - qualifies ip
//   load       - replace pattern with pattern_in and restart filling
//   pattern_in - new pattern value
//   clr_cnt    - synchronous clear of match_cnt
//   op         - one-cycle registered match pulse
//   armed      - PAT_W valid bits are held in history
//   match_cnt  - saturating count of matches
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_DEF),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ip,
    input  logic             ip_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             clr_cnt,
    output logic             op,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(PAT_W + 1);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q, hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             op_q, match;

    // Post-shift view of history and fill; a match is judged on these.
    always_comb begin
        hist_d = {hist_q[PAT_W-2:0], ip};
        fill_d = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
        match  = ip_valid && !load && fill_d == FW'(PAT_W) && hist_d == pat_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            pat_q   <= DEF_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            op_q    <= 1'b0;
        end else if (load) begin
            state_q <= FILL;
            pat_q   <= pattern_in;
            hist_q  <= '0;
            fill_q  <= '0;
            op_q    <= 1'b0;
        end else begin
            op_q <= match;
            if (ip_valid) begin
                hist_q <= hist_d;
                // Non-overlapping mode demands PAT_W fresh bits after every match.
                if (match && !OVERLAP) begin
                    fill_q  <= '0;
                    state_q <= FILL;
                end else begin
                    fill_q  <= fill_d;
                    state_q <= (fill_d == FW'(PAT_W)) ? ARMED : FILL;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clr_cnt),
        .count (match_cnt)
    );

    assign op    = op_q;
    assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed and random stimulus on three detector configurations against a bit-history model
module tb_pattern_detector;

    logic       clk = 1'b0, reset = 1'b1, ip = 1'b0, ip_valid = 1'b0, load = 1'b0, clr_cnt = 1'b0;
    logic [3:0] pattern_in = 4'b0;
    logic       op0, op1, op2, ar0, ar1, ar2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int total = 0;
    int bad = 0;

    int          nb[3];
    logic [31:0] hs[3];
    logic [3:0]  pat[3];
    int          cnt[3];
    logic        eop[3];
    int          cmax[3] = '{255, 255, 3};
    bit          ovl[3]  = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    pattern_detector u0 (.clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt), .op(op0), .armed(ar0), .match_cnt(c0));
    pattern_detector #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt), .op(op1), .armed(ar1), .match_cnt(c1));
    pattern_detector #(.CNT_W(2)) u2 (.clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt), .op(op2), .armed(ar2), .match_cnt(c2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_op0"}, 32'(op0), 32'(eop[0]));
        chk({tag, "_op1"}, 32'(op1), 32'(eop[1]));
        chk({tag, "_op2"}, 32'(op2), 32'(eop[2]));
        chk({tag, "_armed0"}, 32'(ar0), 32'(nb[0] >= 4));
        chk({tag, "_armed1"}, 32'(ar1), 32'(nb[1] >= 4));
        chk({tag, "_armed2"}, 32'(ar2), 32'(nb[2] >= 4));
        chk({tag, "_cnt0"}, 32'(c0), cnt[0]);
        chk({tag, "_cnt1"}, 32'(c1), cnt[1]);
        chk({tag, "_cnt2"}, 32'(c2), cnt[2]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            nb[k]  = 0;
            hs[k]  = '0;
            pat[k] = 4'b1011;
            cnt[k] = 0;
            eop[k] = 1'b0;
        end
    endtask

    task automatic step(input string tag, input logic b, input logic v, input logic ld,
                        input logic [3:0] pin, input logic clr);
        @(negedge clk);
        ip = b; ip_valid = v; load = ld; pattern_in = pin; clr_cnt = clr;
        for (int k = 0; k < 3; k++) begin
            logic m;
            m = 1'b0;
            if (ld) begin
                pat[k] = pin;
                nb[k]  = 0;
                hs[k]  = '0;
            end else if (v) begin
                hs[k] = {hs[k][30:0], b};
                nb[k]++;
                m = (nb[k] >= 4) && (hs[k][3:0] == pat[k]);
                if (m && !ovl[k]) nb[k] = 0;
            end
            if (clr) cnt[k] = 0;
            else if (m && cnt[k] < cmax[k]) cnt[k]++;
            eop[k] = m;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic bits(input string tag, input logic [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, s[i], 1'b1, 1'b0, 4'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        ip_valid = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #11;
        check_all("reset");
        reset = 1'b1;

        bits("seq_ovl", 16'b1011011, 7);
        chk("seq_ovl_cnt_overlap", 32'(c0), 32'd2);
        chk("seq_ovl_cnt_nonoverlap", 32'(c1), 32'd1);

        step("gap_load", 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
        bits("gap", 16'b01, 2);
        step("gap_idle", 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        step("gap_idle", 1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
        bits("gap", 16'b10, 2);
        chk("gap_op", 32'(op0), 32'd1);

        step("sat_load", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        bits("sat", 16'hff, 8);
        chk("sat_hold", 32'(c2), 32'd3);
        step("clr_match", 1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
        chk("clr_match_op", 32'(op2), 32'd1);
        chk("clr_match_cnt", 32'(c2), 32'd0);

        do_reset("rst_clean");
        bits("prerst", 16'b101, 3);
        do_reset("rst_mid");
        bits("postrst", 16'b111011, 6);
        chk("postrst_op", 32'(op0), 32'd1);

        bits("ldm", 16'b101, 3);
        step("ld_on_match", 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        chk("ld_on_match_op", 32'(op0), 32'd0);
        chk("ld_on_match_armed", 32'(ar0), 32'd0);
        bits("newpat", 16'b0110, 4);
        step("ld_clr", 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            step("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter DEF_PAT, default 4'b1011: pattern value loaded at reset, PAT_W bits wide.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ip  input  1  serial data bit; oldest bit first, matched MSB-first against the pattern.
REQ-008 ip_valid  input  1  ip is sampled only on edges where ip_valid=1.
REQ-009 load  input  1  loads pattern_in as the new pattern on this edge.
REQ-010 pattern_in  input  PAT_W  new pattern value, used only when load=1.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 op  output  1  registered match pulse.
REQ-013 armed  output  1  high when PAT_W valid bits are held in history.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 The block SHALL keep a PAT_W-bit history shift register and a fill counter (0..PAT_W) of valid bits held.
REQ-016 The state machine SHALL have two states: FILL (fill<PAT_W) and ARMED (fill=PAT_W); armed=1 only in ARMED.
REQ-017 On an edge with ip_valid=1 and load=0, ip SHALL shift in at the LSB and fill SHALL increment, saturating at PAT_W.
REQ-018 A match SHALL occur on an ip_valid edge when the post-shift fill equals PAT_W and the post-shift history equals the pattern.
REQ-019 op SHALL be 1 for exactly the one cycle following the matching edge (latency 1), and 0 otherwise, including during ip_valid=0 gaps.
REQ-020 With OVERLAP=1, history and fill SHALL be retained after a match, so a new match can occur on the next valid bit.
REQ-021 With OVERLAP=0, fill SHALL reset to 0 on a match, so the next match needs PAT_W fresh valid bits.
REQ-022 load=1 SHALL replace the pattern, clear the history and fill (state FILL), and suppress any match on that edge; ip is ignored on that edge.
REQ-023 match_cnt SHALL increment by 1 on each match and saturate at 2^CNT_W-1 without wrapping.
REQ-024 clr_cnt=1 SHALL set match_cnt to 0; if it coincides with a match, clr_cnt wins (result 0) but op still pulses.
REQ-025 load and clr_cnt on the same edge SHALL both take effect.
REQ-026 Edges with ip_valid=0 SHALL leave history, fill and state unchanged.

Reset
REQ-027 Asserting reset (low) SHALL immediately force op=0, armed=0, match_cnt=0, fill=0, history=0, pattern=DEF_PAT, state=FILL, independent of clk.
REQ-028 Reset asserted mid-sequence SHALL discard partial history; detection restarts from FILL after reset deasserts.
REQ-029 The first edge after deassertion SHALL be treated as a normal functional edge.

Structure
REQ-030 Shared package pattern_detector_pkg SHALL hold the state encoding (FILL, ARMED) and the default values of PAT_W, DEF_PAT and CNT_W.
REQ-031 The saturating match counter SHALL be a sub-module, sat_counter (parameter CNT_W; inputs inc and clr, clr priority).
REQ-032 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-033 Defaults (OVERLAP=1, pattern 1011), valid stream 1,0,1,1,0,1,1 -> op pulses after bit 4 and after bit 7; match_cnt=2.
REQ-034 OVERLAP=0, pattern 1011, stream 1,0,1,1,0,1,1 -> op pulses only after bit 4; match_cnt=1; armed=0 after bit 4 until bit 8.
REQ-035 load pattern_in=0110, then stream 0,1,1,0 with ip_valid deasserted for 2 cycles between bits 2 and 3 -> single op pulse after bit 4; no pulse during the gap.
REQ-036 CNT_W=2, repeated pattern 1111 with OVERLAP=1, 8 ones -> match_cnt reaches 3 and holds; clr_cnt coincident with a match -> match_cnt=0 and op=1.
REQ-037 Reset asserted low between clock edges after bits 1,0,1 -> outputs clear immediately; after release, 1,1 gives no match; a full 1,0,1,1 then matches.
REQ-038 load asserted on the edge that would complete 1011 -> no op pulse, armed=0, new pattern active from the next edge.
